// File: rtl/noc_route_pkg.sv
// Shared route definitions for the XY mesh router: port codes, request types,
// route-unit state encoding and the dimension-order port decision.
package noc_route_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] PORT_L = 3'd0;
  localparam logic [2:0] PORT_N = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_S = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;

  localparam logic UNICAST   = 1'b0;
  localparam logic MULTICAST = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } route_state_e;

  // X is resolved before Y, so a destination leaves on E/W until its column matches.
  function automatic logic [2:0] xy_port(input int dx, input int dy, input int mx, input int my);
    logic [2:0] p;
    if (dx > mx) begin
      p = PORT_E;
    end else if (dx < mx) begin
      p = PORT_W;
    end else if (dy > my) begin
      p = PORT_S;
    end else if (dy < my) begin
      p = PORT_N;
    end else begin
      p = PORT_L;
    end
    return p;
  endfunction

endpackage

// File: rtl/mc_partition.sv
// Combinational split of a multicast bitmap into per-port subsets, plus the
// output port for a unicast destination id.
module mc_partition
  import noc_route_pkg::*;
#(
  parameter int  XDIM    = 5,
  parameter int  YDIM    = 4,
  parameter int  MY_XPOS = 0,
  parameter int  MY_YPOS = 0,
  localparam int NODES   = XDIM * YDIM,
  localparam int NODEW   = $clog2(NODES)
) (
  input  logic [NODEW-1:0]              in_addr,
  input  logic [NODES-1:0]              in_mask,
  output logic [NPORTS-1:0][NODES-1:0]  sub_mask,
  output logic [2:0]                    uni_port
);

  // Each node's port is a constant of its index, so this reduces to wiring.
  always_comb begin
    sub_mask = '0;
    for (int i = 0; i < NODES; i++) begin
      sub_mask[xy_port(i / YDIM, i % YDIM, MY_XPOS, MY_YPOS)][i] = in_mask[i];
    end
  end

  // Unicast port decode; out-of-range ids are filtered by the caller.
  always_comb begin
    uni_port = xy_port(int'(in_addr) / YDIM, int'(in_addr) % YDIM, MY_XPOS, MY_YPOS);
  end

endmodule

// File: rtl/mc_route_split.sv
// Route unit for the router input stage: accepts one head request, partitions
// it per output port and issues one port request per cycle in L,N,E,S,W order.
module mc_route_split
  import noc_route_pkg::*;
#(
  parameter int  XDIM    = 5,
  parameter int  YDIM    = 4,
  parameter int  MY_XPOS = 0,
  parameter int  MY_YPOS = 0,
  localparam int NODES   = XDIM * YDIM,
  localparam int NODEW   = $clog2(NODES)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_type,
  input  logic [NODEW-1:0] in_addr,
  input  logic [NODES-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_port,
  output logic             out_type,
  output logic [NODEW-1:0] out_addr,
  output logic [NODES-1:0] out_mask,
  output logic             out_last,
  output logic             err
);

  route_state_e                 state_r, state_s;
  logic [NPORTS-1:0]            pend_r, pend_s;
  logic [NPORTS-1:0][NODES-1:0] sub_r, sub_s, part_mask_s;
  logic                         type_r, type_s;
  logic [NODEW-1:0]             addr_r, addr_s;
  logic                         drop_s;
  logic                         addr_ok_s;
  logic [2:0]                   uni_port_s;
  logic [2:0]                   next_port_s;

  function automatic logic [2:0] first_port(input logic [NPORTS-1:0] p);
    logic [2:0] r;
    r = PORT_L;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (p[i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

  function automatic logic one_left(input logic [NPORTS-1:0] p);
    return (p != '0) && ((p & (p - NPORTS'(1))) == '0);
  endfunction

  mc_partition #(
    .XDIM    (XDIM),
    .YDIM    (YDIM),
    .MY_XPOS (MY_XPOS),
    .MY_YPOS (MY_YPOS)
  ) u_part (
    .in_addr  (in_addr),
    .in_mask  (in_mask),
    .sub_mask (part_mask_s),
    .uni_port (uni_port_s)
  );

  assign addr_ok_s   = (int'(in_addr) < NODES);
  assign next_port_s = first_port(pend_s);

  // Next-state logic: capture a head in IDLE, retire one pending port per handshake in ISSUE.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    sub_s   = sub_r;
    type_s  = type_r;
    addr_s  = addr_r;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_type == MULTICAST) begin
            if (in_mask == '0) begin
              drop_s = 1'b1;
            end else begin
              sub_s  = part_mask_s;
              type_s = MULTICAST;
              addr_s = '0;
              for (int p = 0; p < NPORTS; p++) begin
                pend_s[p] = |part_mask_s[p];
              end
              state_s = ST_ISSUE;
            end
          end else begin
            if (!addr_ok_s) begin
              drop_s = 1'b1;
            end else begin
              sub_s  = '0;
              type_s = UNICAST;
              addr_s = in_addr;
              pend_s = '0;
              pend_s[uni_port_s] = 1'b1;
              state_s = ST_ISSUE;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          pend_s[first_port(pend_r)] = 1'b0;
          if (pend_s == '0) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pend_s  = '0;
      end
    endcase
  end

  // State and output registers; outputs are loaded from the next pending set.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r   <= ST_IDLE;
      pend_r    <= '0;
      sub_r     <= '0;
      type_r    <= UNICAST;
      addr_r    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_port  <= PORT_L;
      out_type  <= UNICAST;
      out_addr  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      pend_r    <= pend_s;
      sub_r     <= sub_s;
      type_r    <= type_s;
      addr_r    <= addr_s;
      in_ready  <= (state_s == ST_IDLE);
      out_valid <= (state_s == ST_ISSUE);
      err       <= drop_s;
      if (state_s == ST_ISSUE) begin
        out_port <= next_port_s;
        out_type <= type_s;
        out_addr <= addr_s;
        out_mask <= sub_s[next_port_s];
        out_last <= one_left(pend_s);
      end else begin
        out_port <= PORT_L;
        out_type <= UNICAST;
        out_addr <= '0;
        out_mask <= '0;
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_route_split.sv
// Scoreboard bench for mc_route_split: a 5x4 mesh router at (2,1) and a 3x3
// corner router at (0,0), checked against a dimension-order reference model.
module tb_mc_route_split;
  import noc_route_pkg::*;

  typedef struct packed {
    logic [2:0]  port;
    logic        typ;
    logic [4:0]  addr;
    logic [19:0] mask;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_;

  logic a_in_valid, a_in_ready, a_in_type, a_out_valid, a_out_ready, a_out_type, a_out_last, a_err;
  logic [4:0]  a_in_addr, a_out_addr;
  logic [19:0] a_in_mask, a_out_mask;
  logic [2:0]  a_out_port;
  logic b_in_valid, b_in_ready, b_in_type, b_out_valid, b_out_ready, b_out_type, b_out_last, b_err;
  logic [3:0]  b_in_addr, b_out_addr;
  logic [8:0]  b_in_mask, b_out_mask;
  logic [2:0]  b_out_port;

  mc_route_split #(.XDIM(5), .YDIM(4), .MY_XPOS(2), .MY_YPOS(1)) u_dut_a (
    .clk(clk), .rst_(rst_), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_type(a_in_type),
    .in_addr(a_in_addr), .in_mask(a_in_mask), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_port(a_out_port), .out_type(a_out_type), .out_addr(a_out_addr), .out_mask(a_out_mask),
    .out_last(a_out_last), .err(a_err));

  mc_route_split #(.XDIM(3), .YDIM(3), .MY_XPOS(0), .MY_YPOS(0)) u_dut_b (
    .clk(clk), .rst_(rst_), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_type(b_in_type),
    .in_addr(b_in_addr), .in_mask(b_in_mask), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_port(b_out_port), .out_type(b_out_type), .out_addr(b_out_addr), .out_mask(b_out_mask),
    .out_last(b_out_last), .err(b_err));

  int   n_cmp = 0, n_bad = 0;
  exp_t q0[$], q1[$];
  int   seq_a[$];
  int   pops[2];
  int   rmode[2];
  int   scnt[2];
  int   err_seen = 0, err_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic vld(input int s);
    return (s == 0) ? a_out_valid : b_out_valid;
  endfunction
  function automatic logic rdy(input int s);
    return (s == 0) ? a_out_ready : b_out_ready;
  endfunction
  function automatic logic in_rdy(input int s);
    return (s == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic exp_t cur_out(input int s);
    exp_t e;
    if (s == 0) begin
      e.port = a_out_port; e.typ = a_out_type; e.addr = a_out_addr;
      e.mask = a_out_mask; e.last = a_out_last;
    end else begin
      e.port = b_out_port; e.typ = b_out_type; e.addr = {1'b0, b_out_addr};
      e.mask = {11'b0, b_out_mask}; e.last = b_out_last;
    end
    return e;
  endfunction

  function automatic exp_t mk(input int port, input logic typ, input logic [4:0] addr,
                              input logic [19:0] mask, input logic last);
    exp_t e;
    e.port = 3'(port); e.typ = typ; e.addr = addr; e.mask = mask; e.last = last;
    return e;
  endfunction

  task automatic push(input int s, input exp_t e);
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Dimension-order rule: column first, then row.
  function automatic int dport(input int id, input int yd, input int mx, input int my);
    int dx, dy;
    dx = id / yd;
    dy = id % yd;
    if (dx > mx) return 2;
    if (dx < mx) return 4;
    if (dy > my) return 3;
    if (dy < my) return 1;
    return 0;
  endfunction

  task automatic model(input int s, input logic typ, input logic [4:0] addr,
                       input logic [19:0] mask, output bit drop);
    int yd, n, mx, my, k, idx;
    logic [19:0] sub[5];
    yd = (s == 0) ? 4 : 3;
    n  = (s == 0) ? 20 : 9;
    mx = (s == 0) ? 2 : 0;
    my = (s == 0) ? 1 : 0;
    drop = 1'b0;
    for (int p = 0; p < 5; p++) sub[p] = 20'h0;
    if (typ == 1'b0) begin
      if (int'(addr) >= n) drop = 1'b1;
      else push(s, mk(dport(int'(addr), yd, mx, my), 1'b0, addr, 20'h0, 1'b1));
    end else if (mask == 20'h0) begin
      drop = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) if (mask[i]) sub[dport(i, yd, mx, my)][i] = 1'b1;
      k = 0;
      for (int p = 0; p < 5; p++) if (sub[p] != 20'h0) k++;
      idx = 0;
      for (int p = 0; p < 5; p++) begin
        if (sub[p] != 20'h0) begin
          idx++;
          push(s, mk(p, 1'b1, 5'd0, sub[p], idx == k));
        end
      end
    end
  endtask

  // Present one request and wait (bounded) for it to be accepted; returns 1 time unit after the accept edge.
  task automatic send(input int s, input logic typ, input logic [4:0] addr,
                      input logic [19:0] mask, input bit use_model);
    bit ok, drop;
    ok = 1'b0;
    @(negedge clk);
    if (s == 0) begin
      a_in_valid = 1'b1; a_in_type = typ; a_in_addr = addr; a_in_mask = mask;
    end else begin
      b_in_valid = 1'b1; b_in_type = typ; b_in_addr = addr[3:0]; b_in_mask = mask[8:0];
    end
    for (int k = 0; k < 300 && !ok; k++) begin
      if (in_rdy(s)) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      if (use_model) begin
        model(s, typ, addr, mask, drop);
        if (drop) err_exp++;
      end
      @(posedge clk);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout inst%0d: in_ready got 0 expected 1", s);
    end
    #1;
    if (s == 0) a_in_valid = 1'b0;
    else        b_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk); #1;
      done = (q0.size() == 0) && (q1.size() == 0) && !a_out_valid && !b_out_valid
             && a_in_ready && b_in_ready;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  task automatic check_order();
    chk("order_len", 32'(seq_a.size()), 32'd5);
    for (int i = 0; i < seq_a.size(); i++) chk("order_port", 32'(seq_a[i]), 32'(i));
  endtask

  // Backpressure generator: always ready, random, or three stall cycles per request.
  always begin
    logic r;
    @(posedge clk); #2;
    for (int s = 0; s < 2; s++) begin
      case (rmode[s])
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          if (vld(s)) begin
            if (scnt[s] < 3) begin r = 1'b0; scnt[s]++; end
            else begin r = 1'b1; scnt[s] = 0; end
          end else begin
            r = 1'b0;
          end
        end
      endcase
      if (s == 0) a_out_ready = r;
      else        b_out_ready = r;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold-during-stall.
  always @(negedge clk) begin : mon
    exp_t act, e;
    bit   stall_p[2];
    exp_t prev[2];
    for (int s = 0; s < 2; s++) begin
      act = cur_out(s);
      if (!rst_) begin
        stall_p[s] = 1'b0;
      end else begin
        if (stall_p[s]) begin
          chk("hold_valid", 32'(vld(s)), 32'd1);
          chk("hold_data", 32'(act), 32'(prev[s]));
        end
        if (vld(s) && rdy(s)) begin
          if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out inst%0d: got %0h expected none", s, act);
          end else begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk((s == 0) ? "out_a" : "out_b", 32'(act), 32'(e));
          end
          pops[s]++;
          if (s == 0) seq_a.push_back(int'(act.port));
        end
        stall_p[s] = vld(s) && !rdy(s);
        prev[s] = act;
      end
    end
    if (rst_) err_seen += int'(a_err) + int'(b_err);
  end

  initial begin
    logic [19:0] m;
    logic [4:0]  ad;
    int          s, base;
    bit          hit;
    rst_ = 1'b0;
    a_in_valid = 1'b0; a_in_type = 1'b0; a_in_addr = 5'd0; a_in_mask = 20'h0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_type = 1'b0; b_in_addr = 4'd0; b_in_mask = 9'h0;  b_out_ready = 1'b1;
    rmode[0] = 0; rmode[1] = 0; scnt[0] = 0; scnt[1] = 0; pops[0] = 0; pops[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_outputs", 32'(cur_out(0)), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_b", {30'd0, b_in_ready, b_out_valid}, 32'd2);
    rst_ = 1'b1;

    // Unicast to node 13 (x=3,y=1) leaves east.
    push(0, mk(2, 1'b0, 5'd13, 20'h0, 1'b1));
    send(0, 1'b0, 5'd13, 20'h0, 1'b0);
    chk("uni_latency_valid", 32'(a_out_valid), 32'd1);
    chk("uni_port", 32'(a_out_port), 32'd2);
    chk("uni_last", 32'(a_out_last), 32'd1);
    chk("uni_busy", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("uni_ready_back", 32'(a_in_ready), 32'd1);
    chk("uni_valid_gone", 32'(a_out_valid), 32'd0);
    wait_drain();

    // Multicast {9,5,17,8,10}: unthrottled, then with three stall cycles per request.
    for (int pass = 0; pass < 2; pass++) begin
      rmode[0] = pass * 2;
      seq_a.delete();
      push(0, mk(0, 1'b1, 5'd0, 20'h00200, 1'b0));
      push(0, mk(1, 1'b1, 5'd0, 20'h00100, 1'b0));
      push(0, mk(2, 1'b1, 5'd0, 20'h20000, 1'b0));
      push(0, mk(3, 1'b1, 5'd0, 20'h00400, 1'b0));
      push(0, mk(4, 1'b1, 5'd0, 20'h00020, 1'b1));
      send(0, 1'b1, 5'd0, 20'h20720, 1'b0);
      wait_drain();
      check_order();
    end
    rmode[0] = 0;

    // Drops: empty multicast, then unicast to out-of-range id 20.
    for (int d = 0; d < 2; d++) begin
      err_exp++;
      send(0, 1'(1 - d), (d == 0) ? 5'd0 : 5'd20, 20'h0, 1'b0);
      chk("drop_err_pulse", 32'(a_err), 32'd1);
      chk("drop_in_ready", 32'(a_in_ready), 32'd1);
      chk("drop_no_valid", 32'(a_out_valid), 32'd0);
      @(posedge clk); #1;
      chk("drop_err_end", 32'(a_err), 32'd0);
      chk("drop_no_valid2", 32'(a_out_valid), 32'd0);
    end

    // Reset after two of four requests; the remaining subsets must never appear.
    push(0, mk(0, 1'b1, 5'd0, 20'h00200, 1'b0));
    push(0, mk(2, 1'b1, 5'd0, 20'h20000, 1'b0));
    push(0, mk(3, 1'b1, 5'd0, 20'h00400, 1'b0));
    push(0, mk(4, 1'b1, 5'd0, 20'h00020, 1'b1));
    base = pops[0];
    send(0, 1'b1, 5'd0, 20'h20620, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk); #1;
      hit = (pops[0] >= base + 2);
    end
    chk("rst_mid_reached", 32'(hit), 32'd1);
    @(posedge clk); #1;
    chk("rst_mid_pending", 32'(a_out_valid), 32'd1);
    rst_ = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(a_out_valid), 32'd0);
    chk("rst_mid_ready", 32'(a_in_ready), 32'd1);
    q0.delete();
    @(negedge clk);
    rst_ = 1'b1;
    send(0, 1'b0, 5'd7, 20'h0, 1'b1);
    wait_drain();

    // Corner router (0,0) on a 3x3 mesh with every node set.
    push(1, mk(0, 1'b1, 5'd0, 20'h00001, 1'b0));
    push(1, mk(2, 1'b1, 5'd0, 20'h001F8, 1'b0));
    push(1, mk(3, 1'b1, 5'd0, 20'h00006, 1'b1));
    send(1, 1'b1, 5'd0, 20'h001FF, 1'b0);
    wait_drain();

    // Randomised traffic with random backpressure on both routers.
    rmode[0] = 1; rmode[1] = 1;
    for (int it = 0; it < 120; it++) begin
      s  = int'($urandom_range(0, 1));
      ad = (s == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      m  = 20'($urandom) & ((s == 0) ? 20'hFFFFF : 20'h001FF);
      if ($urandom_range(0, 7) == 0) m = 20'h0;
      send(s, 1'($urandom_range(0, 1)), ad, m, 1'b1);
    end
    wait_drain();
    chk("err_count", 32'(err_seen), 32'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
